// File: rtl/sigmoid_arbiter_if.sv
// Handshake bundle between N neuron requesters, the arbiter and the shared sigmoid unit.
// The arbiter takes the slave modport; requesters and the unit together form the master side.
interface sigmoid_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req_arg_stb;
    logic [16*N-1:0] req_arg_dat;
    logic [N-1:0]    req_arg_rdy;
    logic [N-1:0]    req_res_stb;
    logic [7:0]      req_res_dat;
    logic [N-1:0]    req_res_rdy;
    logic [N-1:0]    req_err_stb;
    logic [16*N-1:0] req_err_dat;
    logic [N-1:0]    req_err_rdy;
    logic [N-1:0]    req_fbk_stb;
    logic [15:0]     req_fbk_dat;
    logic [N-1:0]    req_fbk_rdy;

    logic            sig_en;
    logic            sig_arg_stb;
    logic [15:0]     sig_arg_dat;
    logic            sig_arg_rdy;
    logic            sig_res_stb;
    logic [7:0]      sig_res_dat;
    logic            sig_res_rdy;
    logic            sig_err_stb;
    logic [15:0]     sig_err_dat;
    logic            sig_err_rdy;
    logic            sig_fbk_stb;
    logic [15:0]     sig_fbk_dat;
    logic            sig_fbk_rdy;

    modport slave (
        input  req_arg_stb, req_arg_dat, req_res_rdy, req_err_stb, req_err_dat, req_fbk_rdy,
        input  sig_arg_rdy, sig_res_stb, sig_res_dat, sig_err_rdy, sig_fbk_stb, sig_fbk_dat,
        output req_arg_rdy, req_res_stb, req_res_dat, req_err_rdy, req_fbk_stb, req_fbk_dat,
        output sig_en, sig_arg_stb, sig_arg_dat, sig_res_rdy, sig_err_stb, sig_err_dat, sig_fbk_rdy
    );

    modport master (
        output req_arg_stb, req_arg_dat, req_res_rdy, req_err_stb, req_err_dat, req_fbk_rdy,
        output sig_arg_rdy, sig_res_stb, sig_res_dat, sig_err_rdy, sig_fbk_stb, sig_fbk_dat,
        input  req_arg_rdy, req_res_stb, req_res_dat, req_err_rdy, req_fbk_stb, req_fbk_dat,
        input  sig_en, sig_arg_stb, sig_arg_dat, sig_res_rdy, sig_err_stb, sig_err_dat, sig_fbk_rdy
    );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one sigmoid activation/derivative unit between N requesters.
// The grant is held for a whole transaction: ARG, RES and, in training mode, ERR and FBK.
//
// state | meaning
// IDLE  | no owner; pick the next requester in rotation, latch training mode
// ARG   | argument channel routed between owner and unit
// RES   | result channel routed from unit to owner
// ERR   | error channel routed from owner to unit (training only)
// FBK   | feedback channel routed from unit to owner (training only)
module sigmoid_arbiter #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    sigmoid_arbiter_if.slave    bus,
    output logic [N-1:0]        gnt_o,
    output logic                busy_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_RES  = 3'd2,
        S_ERR  = 3'd3,
        S_FBK  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic            mode_q, mode_d;

    logic            any_req;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   sel;

    logic [N-1:0]    arg_rdy, res_stb, err_rdy, fbk_stb;
    logic            arg_stb, res_rdy, err_stb, fbk_rdy;
    logic [15:0]     arg_dat, err_dat;

    // Scan from the farthest candidate down so the nearest one after last_q wins.
    always_comb begin
        any_req = 1'b0;
        win     = last_q;
        cand    = last_q;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % N);
            if (bus.req_arg_stb[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    // last_q always holds the current owner once granted.
    assign sel = last_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        arg_rdy = '0;
        res_stb = '0;
        err_rdy = '0;
        fbk_stb = '0;
        arg_stb = 1'b0;
        res_rdy = 1'b0;
        err_stb = 1'b0;
        fbk_rdy = 1'b0;
        arg_dat = '0;
        err_dat = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_ARG;
                    last_d     = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    mode_d     = en_i;
                end
            end
            S_ARG: begin
                arg_stb      = bus.req_arg_stb[sel];
                arg_dat      = bus.req_arg_dat[{sel, 4'b0000} +: 16];
                arg_rdy[sel] = bus.sig_arg_rdy;
                if (arg_stb && bus.sig_arg_rdy) state_d = S_RES;
            end
            S_RES: begin
                res_stb[sel] = bus.sig_res_stb;
                res_rdy      = bus.req_res_rdy[sel];
                if (bus.sig_res_stb && res_rdy) begin
                    if (mode_q) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            S_ERR: begin
                err_stb      = bus.req_err_stb[sel];
                err_dat      = bus.req_err_dat[{sel, 4'b0000} +: 16];
                err_rdy[sel] = bus.sig_err_rdy;
                if (err_stb && bus.sig_err_rdy) state_d = S_FBK;
            end
            S_FBK: begin
                fbk_stb[sel] = bus.sig_fbk_stb;
                fbk_rdy      = bus.req_fbk_rdy[sel];
                if (bus.sig_fbk_stb && fbk_rdy) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = state_t'('x);
                gnt_d   = 'x;
                last_d  = 'x;
                mode_d  = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N - 1);
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
        end
    end

    state_legal_a: assert property (@(posedge clk) disable iff (rst)
        state_q inside {S_IDLE, S_ARG, S_RES, S_ERR, S_FBK})
        else $fatal(1, "sigmoid_arbiter: illegal state encoding %0d", state_q);

    assign bus.req_arg_rdy = arg_rdy;
    assign bus.req_res_stb = res_stb;
    assign bus.req_err_rdy = err_rdy;
    assign bus.req_fbk_stb = fbk_stb;
    assign bus.req_res_dat = bus.sig_res_dat;
    assign bus.req_fbk_dat = bus.sig_fbk_dat;
    assign bus.sig_en      = mode_q;
    assign bus.sig_arg_stb = arg_stb;
    assign bus.sig_arg_dat = arg_dat;
    assign bus.sig_res_rdy = res_rdy;
    assign bus.sig_err_stb = err_stb;
    assign bus.sig_err_dat = err_dat;
    assign bus.sig_fbk_rdy = fbk_rdy;

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != S_IDLE);
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: queue-driven requesters, a stub sigmoid unit, and a
// transaction-level ownership model compared against every DUT output each cycle.
module tb_sigmoid_arbiter;
    localparam int N = 4;
    localparam int P_IDLE = 0, P_ARG = 1, P_RES = 2, P_ERR = 3, P_FBK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [N-1:0] gnt;
    logic busy;

    sigmoid_arbiter_if #(.N(N)) bus ();

    sigmoid_arbiter #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .bus    (bus),
        .gnt_o  (gnt),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Requester and unit stub state
    logic [15:0] arg_q [N][$];
    bit          res_rdy_k [N] = '{default: 1'b1};
    bit          want_err [N];
    logic [15:0] err_v [N];
    bit          err_pend [N];
    logic [7:0]  res_log [N][$];
    logic [15:0] fbk_log [N][$];
    int          u_ph = 0;
    int          u_cnt = 0;
    logic [15:0] u_arg = '0;
    logic [15:0] u_err = '0;
    bit          u_mode = 1'b0;

    // Ownership model
    int  m_owner = -1;
    int  m_ph    = P_IDLE;
    int  m_last  = N - 1;
    bit  m_mode  = 1'b0;
    int  m_log [$];

    initial begin : driver
        bus.req_arg_stb = '0; bus.req_arg_dat = '0; bus.req_res_rdy = '0;
        bus.req_err_stb = '0; bus.req_err_dat = '0; bus.req_fbk_rdy = '0;
        bus.sig_arg_rdy = 1'b0; bus.sig_res_stb = 1'b0; bus.sig_res_dat = '0;
        bus.sig_err_rdy = 1'b0; bus.sig_fbk_stb = 1'b0; bus.sig_fbk_dat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                u_ph = 0;
                for (int i = 0; i < N; i++) err_pend[i] = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req_arg_stb[i] && bus.req_arg_rdy[i] && arg_q[i].size() > 0)
                        void'(arg_q[i].pop_front());
                    if (bus.req_res_stb[i] && bus.req_res_rdy[i]) begin
                        res_log[i].push_back(bus.req_res_dat);
                        if (want_err[i]) err_pend[i] = 1'b1;
                    end
                    if (bus.req_err_stb[i] && bus.req_err_rdy[i]) err_pend[i] = 1'b0;
                    if (bus.req_fbk_stb[i] && bus.req_fbk_rdy[i]) fbk_log[i].push_back(bus.req_fbk_dat);
                end
                case (u_ph)
                    0: if (bus.sig_arg_stb && bus.sig_arg_rdy) begin
                           u_arg = bus.sig_arg_dat; u_mode = bus.sig_en; u_cnt = 2; u_ph = 1;
                       end
                    1: begin u_cnt--; if (u_cnt == 0) u_ph = 2; end
                    2: if (bus.sig_res_stb && bus.sig_res_rdy) u_ph = u_mode ? 3 : 0;
                    3: if (bus.sig_err_stb && bus.sig_err_rdy) begin
                           u_err = bus.sig_err_dat; u_cnt = 1; u_ph = 4;
                       end
                    4: begin u_cnt--; if (u_cnt == 0) u_ph = 5; end
                    5: if (bus.sig_fbk_stb && bus.sig_fbk_rdy) u_ph = 0;
                    default: u_ph = 0;
                endcase
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                bus.req_arg_stb[i]          = (arg_q[i].size() > 0);
                bus.req_arg_dat[16*i +: 16] = (arg_q[i].size() > 0) ? arg_q[i][0] : 16'h0000;
                bus.req_res_rdy[i]          = res_rdy_k[i];
                bus.req_err_stb[i]          = err_pend[i];
                bus.req_err_dat[16*i +: 16] = err_v[i];
                bus.req_fbk_rdy[i]          = 1'b1;
            end
            bus.sig_arg_rdy = (u_ph == 0);
            bus.sig_res_stb = (u_ph == 2);
            bus.sig_res_dat = u_arg[15:8] + 8'h11;
            bus.sig_err_rdy = (u_ph == 3);
            bus.sig_fbk_stb = (u_ph == 5);
            bus.sig_fbk_dat = u_err + 16'h0011;
        end
    end

    // The owner sees the unit's channel of the current phase; everyone else sees zeros.
    initial begin : model
        logic [N-1:0] e_gnt, e_arg_rdy, e_res_stb, e_err_rdy, e_fbk_stb;
        logic         e_a_stb, e_r_rdy, e_e_stb, e_f_rdy;
        logic [15:0]  e_a_dat, e_e_dat;
        bit           found;
        int           c;
        forever begin
            @(negedge clk);
            e_gnt = '0; e_arg_rdy = '0; e_res_stb = '0; e_err_rdy = '0; e_fbk_stb = '0;
            e_a_stb = 1'b0; e_r_rdy = 1'b0; e_e_stb = 1'b0; e_f_rdy = 1'b0;
            e_a_dat = '0; e_e_dat = '0;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                if (m_ph == P_ARG) begin
                    e_a_stb = bus.req_arg_stb[m_owner];
                    e_a_dat = bus.req_arg_dat[16*m_owner +: 16];
                    e_arg_rdy[m_owner] = bus.sig_arg_rdy;
                end else if (m_ph == P_RES) begin
                    e_res_stb[m_owner] = bus.sig_res_stb;
                    e_r_rdy = bus.req_res_rdy[m_owner];
                end else if (m_ph == P_ERR) begin
                    e_e_stb = bus.req_err_stb[m_owner];
                    e_e_dat = bus.req_err_dat[16*m_owner +: 16];
                    e_err_rdy[m_owner] = bus.sig_err_rdy;
                end else if (m_ph == P_FBK) begin
                    e_fbk_stb[m_owner] = bus.sig_fbk_stb;
                    e_f_rdy = bus.req_fbk_rdy[m_owner];
                end
            end
            chk("gnt",         32'(gnt),             32'(e_gnt));
            chk("busy",        32'(busy),            32'(m_ph != P_IDLE));
            chk("sig_en",      32'(bus.sig_en),      32'(m_mode));
            chk("req_arg_rdy", 32'(bus.req_arg_rdy), 32'(e_arg_rdy));
            chk("req_res_stb", 32'(bus.req_res_stb), 32'(e_res_stb));
            chk("req_err_rdy", 32'(bus.req_err_rdy), 32'(e_err_rdy));
            chk("req_fbk_stb", 32'(bus.req_fbk_stb), 32'(e_fbk_stb));
            chk("req_res_dat", 32'(bus.req_res_dat), 32'(bus.sig_res_dat));
            chk("req_fbk_dat", 32'(bus.req_fbk_dat), 32'(bus.sig_fbk_dat));
            chk("sig_arg_stb", 32'(bus.sig_arg_stb), 32'(e_a_stb));
            chk("sig_arg_dat", 32'(bus.sig_arg_dat), 32'(e_a_dat));
            chk("sig_res_rdy", 32'(bus.sig_res_rdy), 32'(e_r_rdy));
            chk("sig_err_stb", 32'(bus.sig_err_stb), 32'(e_e_stb));
            chk("sig_err_dat", 32'(bus.sig_err_dat), 32'(e_e_dat));
            chk("sig_fbk_rdy", 32'(bus.sig_fbk_rdy), 32'(e_f_rdy));
            if (rst) begin
                m_owner = -1; m_ph = P_IDLE; m_last = N - 1; m_mode = 1'b0;
            end else begin
                case (m_ph)
                    P_IDLE: begin
                        found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            c = (m_last + k) % N;
                            if (!found && bus.req_arg_stb[c]) begin
                                found = 1'b1;
                                m_owner = c;
                            end
                        end
                        if (found) begin
                            m_last = m_owner; m_mode = en; m_ph = P_ARG;
                            m_log.push_back(m_owner);
                        end
                    end
                    P_ARG: if (e_a_stb && bus.sig_arg_rdy) m_ph = P_RES;
                    P_RES: if (bus.sig_res_stb && e_r_rdy) begin
                               if (m_mode) m_ph = P_ERR;
                               else begin m_ph = P_IDLE; m_owner = -1; end
                           end
                    P_ERR: if (e_e_stb && bus.sig_err_rdy) m_ph = P_FBK;
                    P_FBK: if (bus.sig_fbk_stb && e_f_rdy) begin m_ph = P_IDLE; m_owner = -1; end
                    default: m_ph = P_IDLE;
                endcase
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic bit quiet();
        bit q;
        q = (m_ph == P_IDLE) && (u_ph == 0);
        for (int i = 0; i < N; i++) if (arg_q[i].size() > 0 || err_pend[i]) q = 1'b0;
        return q;
    endfunction

    function automatic logic [31:0] last_res(input int i);
        return (res_log[i].size() > 0) ? 32'(res_log[i][res_log[i].size()-1]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] last_fbk(input int i);
        return (fbk_log[i].size() > 0) ? 32'(fbk_log[i][fbk_log[i].size()-1]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] log_at(input int k);
        return (m_log.size() > k) ? 32'(m_log[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_done(input string nm, input int lim);
        int c = 0;
        while (!quiet() && c < lim) begin cyc(); c++; end
        chk(nm, 32'(quiet()), 1);
        cyc(1);
    endtask

    task automatic wait_ph(input string nm, input int p, input int lim);
        int c = 0;
        while (m_ph != p && c < lim) begin cyc(); c++; end
        chk(nm, 32'(m_ph), 32'(p));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int fbk_before;

    initial begin : stim
        rst = 1'b1;
        cyc(3);
        chk("rst_gnt",     32'(gnt), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_sig_en",  32'(bus.sig_en), 0);
        chk("rst_arg_rdy", 32'(bus.req_arg_rdy), 0);
        rst = 1'b0;
        cyc(2);

        // Single request from requester 2, non-training
        m_log.delete();
        arg_q[2].push_back(16'h0100);
        wait_done("t1_done", 100);
        chk("t1_winner",   log_at(0), 2);
        chk("t1_unit_arg", 32'(u_arg), 'h0100);
        chk("t1_result",   last_res(2), 'h12);
        chk("t1_gnt_idle", 32'(gnt), 0);

        // All four strobing; rotation from a fresh reset
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        m_log.delete();
        arg_q[0].push_back(16'h1000); arg_q[0].push_back(16'h5000);
        arg_q[1].push_back(16'h2000); arg_q[1].push_back(16'h6000);
        arg_q[2].push_back(16'h3000);
        arg_q[3].push_back(16'h4000);
        wait_done("t2_done", 300);
        chk("t2_count", 32'(m_log.size()), 6);
        for (int k = 0; k < 6; k++) chk("t2_order", log_at(k), 32'(k % 4));
        chk("t2_res0", last_res(0), 'h61);
        chk("t2_res3", last_res(3), 'h51);

        // Training transaction on requester 1; en drops mid-transaction
        en = 1'b1;
        want_err[1] = 1'b1; err_v[1] = 16'h0100;
        arg_q[1].push_back(16'h0000);
        wait_ph("t3_reach_err", P_ERR, 50);
        en = 1'b0;
        cyc(1);
        chk("t3_mode_hold", 32'(bus.sig_en), 1);
        wait_done("t3_done", 100);
        want_err[1] = 1'b0;
        chk("t3_result",   last_res(1), 'h11);
        chk("t3_feedback", last_fbk(1), 'h0111);

        // Owner withholds result ready for 5 cycles
        m_log.delete();
        res_rdy_k[0] = 1'b0;
        arg_q[0].push_back(16'h1234);
        wait_ph("t4_arg", P_ARG, 20);
        arg_q[3].push_back(16'h4321);
        wait_ph("t4_res", P_RES, 20);
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_gnt",  32'(gnt), 'b0001);
            chk("t4_stall_rdy",  32'(bus.sig_res_rdy), 0);
            chk("t4_stall_busy", 32'(busy), 1);
            chk("t4_blocked",    32'(bus.req_arg_rdy), 0);
            cyc(1);
        end
        res_rdy_k[0] = 1'b1;
        wait_done("t4_done", 100);
        chk("t4_order0", log_at(0), 0);
        chk("t4_order1", log_at(1), 3);
        chk("t4_res0",   last_res(0), 'h23);
        chk("t4_res3",   last_res(3), 'h54);

        // Reset during FBK, then requester 0 must win first
        en = 1'b1;
        want_err[2] = 1'b1; err_v[2] = 16'h0300;
        arg_q[2].push_back(16'h0200);
        wait_ph("t5_fbk", P_FBK, 60);
        rst = 1'b1;
        cyc(1);
        chk("t5_gnt",     32'(gnt), 0);
        chk("t5_busy",    32'(busy), 0);
        chk("t5_fbk_stb", 32'(bus.req_fbk_stb), 0);
        chk("t5_fbk_rdy", 32'(bus.sig_fbk_rdy), 0);
        chk("t5_err_rdy", 32'(bus.req_err_rdy), 0);
        rst = 1'b0;
        want_err[2] = 1'b0;
        en = 1'b0;
        cyc(1);
        m_log.delete();
        arg_q[3].push_back(16'h0700);
        arg_q[0].push_back(16'h0800);
        wait_done("t5_done", 100);
        chk("t5_first", log_at(0), 0);
        chk("t5_second", log_at(1), 3);

        // en rises during RES after a non-training grant: no ERR phase
        fbk_before = fbk_log[1].size();
        arg_q[1].push_back(16'h0500);
        wait_ph("t6_res", P_RES, 20);
        en = 1'b1;
        cyc(1);
        chk("t6_sig_en", 32'(bus.sig_en), 0);
        wait_done("t6_done", 100);
        en = 1'b0;
        chk("t6_result", last_res(1), 'h16);
        chk("t6_no_fbk", 32'(fbk_log[1].size()), 32'(fbk_before));
        chk("t6_idle",   32'(busy), 0);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Shares one sigmoid activation/derivative unit between N neuron requesters.
- Grants the unit to one requester at a time in round-robin order.
- Holds the grant for the whole transaction: argument, then result, then (in training mode) error and feedback.
- Routes all four handshake channels between the granted requester and the shared unit. Ungranted requesters are stalled.

Parameters:
N, 4, number of requesters (2..16); IW = $clog2(N) is the derived index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; must also drive the shared unit's rst
en  in  1  training enable, sampled at grant
req_arg_stb  in  N  per-requester argument strobe
req_arg_dat  in  16*N  arguments; requester i occupies [16i+15:16i]
req_arg_rdy  out  N  argument ready, one-hot or zero
req_res_stb  out  N  result strobe, one-hot or zero
req_res_dat  out  8  result data (broadcast)
req_res_rdy  in  N  per-requester result ready
req_err_stb  in  N  per-requester error strobe
req_err_dat  in  16*N  errors, same packing as req_arg_dat
req_err_rdy  out  N  error ready, one-hot or zero
req_fbk_stb  out  N  feedback strobe, one-hot or zero
req_fbk_dat  out  16  feedback data (broadcast)
req_fbk_rdy  in  N  per-requester feedback ready
sig_en  out  1  training enable to the shared unit
sig_arg_stb/sig_arg_dat[16]/sig_arg_rdy  out/out/in  argument channel to the unit
sig_res_stb/sig_res_dat[8]/sig_res_rdy  in/in/out  result channel from the unit
sig_err_stb/sig_err_dat[16]/sig_err_rdy  out/out/in  error channel to the unit
sig_fbk_stb/sig_fbk_dat[16]/sig_fbk_rdy  in/in/out  feedback channel from the unit
gnt  out  N  registered one-hot grant; 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Acknowledge on any channel = stb & rdy on the same cycle.
- States:
  - IDLE: when any req_arg_stb is high, register the grant and go to ARG.
  - ARG: on sig_arg ack, go to RES.
  - RES: on sig_res ack, go to ERR if mode=1, otherwise to IDLE.
  - ERR: on sig_err ack, go to FBK.
  - FBK: on sig_fbk ack, go to IDLE.
  - Encodings outside these states are illegal: simulation prints an error and stops; synthesis assigns x.
- Grant selection in IDLE:
  - Scan indices last+1, last+2, … modulo N; the first index with req_arg_stb high wins.
  - last <= winner; gnt <= onehot(winner); mode <= en.
  - Decision is registered, so there is one IDLE cycle between transactions.
- sig_en = mode. It is constant from grant until return to IDLE; changes on en mid-transaction have no effect.
- Routing is purely combinational while in the owning state; all other outputs are 0 (sel = granted index):
  - ARG: sig_arg_stb = req_arg_stb[sel]; sig_arg_dat = slice sel; req_arg_rdy[sel] = sig_arg_rdy.
  - RES: req_res_stb[sel] = sig_res_stb; sig_res_rdy = req_res_rdy[sel].
  - ERR: sig_err_stb = req_err_stb[sel]; sig_err_dat = slice sel; req_err_rdy[sel] = sig_err_rdy.
  - FBK: req_fbk_stb[sel] = sig_fbk_stb; sig_fbk_rdy = req_fbk_rdy[sel].
- req_res_dat = sig_res_dat and req_fbk_dat = sig_fbk_dat unconditionally. Only the strobes are steered.
- The arbiter adds no latency. Unit latency passes through unchanged.
- A requester that drops req_arg_stb after being granted simply stalls in ARG. There is no timeout.
- Reset values: state=IDLE, gnt=0, busy=0, mode=0, last=N-1 (so requester 0 wins first). All outputs are 0 except the broadcast data buses.
- Reset mid-transaction: the state returns to IDLE on the next edge, dropping the transaction. The shared unit resets on the same rst.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers hold their stb and are served in rotation order.

Test Plan:
- N=4, en=0, only req 2 sends arg 16'h0100 → gnt=4'b0100; sig_arg_dat=16'h0100; req_res_stb[2] pulses with unit result; back to IDLE; gnt=0.
- All 4 requesters strobe continuously, en=0 → grant order 0,1,2,3,0,1; no requester ever sees rdy or stb outside its grant.
- en=1, req 1 arg 16'h0000 then err 16'h0100 → ERR/FBK traversed; req_fbk_stb[1] delivers unit feedback; mode stays 1 when en drops during ERR.
- Granted requester holds req_res_rdy=0 for 5 cycles → state stays RES; sig_res_rdy=0; other requesters blocked; resumes on rdy.
- Assert rst during FBK → next cycle state IDLE, gnt=0, all strobes/rdys 0; first new grant goes to requester 0.
- en=0 at grant, en=1 during RES → return to IDLE after result; no ERR phase.
